// File: rtl/cam_init_pkg.sv
// Shared types and constants for the camera register-init sequencer.
package cam_init_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_CHECK,
        S_GAP,
        S_DELAY,
        S_DONE,
        S_FAIL
    } cam_state_e;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } cam_entry_t;

    localparam logic [7:0] ADDR_END   = 8'hFF;
    localparam logic [7:0] ADDR_DELAY = 8'hFE;

    // SCCB device IDs used by the downstream driver; kept here for reference.
    localparam logic [7:0] IIC_WR_ID  = 8'h42;
    localparam logic [7:0] IIC_RD_ID  = 8'h43;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cam_reg_rom.sv
// Default camera configuration table: {register address, value} per index.
// 0xFE entries are delays (value x delay unit), 0xFF marks the end.
module cam_reg_rom
    import cam_init_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic [IDX_W-1:0] index,
    output cam_entry_t       entry
);

    always_comb begin
        entry = '{addr: ADDR_END, val: 8'h00};
        case (int'(index))
            0:       entry = '{addr: 8'h12,       val: 8'h80};
            1:       entry = '{addr: ADDR_DELAY,  val: 8'h02};  // settle after soft reset
            2:       entry = '{addr: 8'h11,       val: 8'h01};
            3:       entry = '{addr: 8'h0C,       val: 8'h04};
            4:       entry = '{addr: 8'h3E,       val: 8'h19};
            5:       entry = '{addr: ADDR_DELAY,  val: 8'h00};
            6:       entry = '{addr: 8'h70,       val: 8'h3A};
            7:       entry = '{addr: 8'h71,       val: 8'h35};
            default: entry = '{addr: ADDR_END,    val: 8'h00};
        endcase
    end

endmodule

// File: rtl/cam_reg_init.sv
// Camera register-configuration sequencer feeding the SCCB/IIC write driver.
// Build option: CAM_INIT_RETRY_EN enables per-entry retries on NACK/timeout.
//
// state        | meaning
// S_IDLE       | waiting for start after reset
// S_FETCH      | decode table entry at idx
// S_ISSUE      | raise one-cycle iic_wr_en
// S_WAIT_START | wait for driver to drop work_done
// S_WAIT_DONE  | wait for driver to raise work_done
// S_CHECK      | judge ack / timeout
// S_GAP        | idle cycles between writes (or before a retry)
// S_DELAY      | delay pseudo-entry countdown
// S_DONE       | table completed
// S_FAIL       | entry failed, fail_index valid
module cam_reg_init
    import cam_init_pkg::*;
#(
    parameter int TABLE_DEPTH       = 128,
    parameter int GAP_CYCLES        = 16,
    parameter int DELAY_UNIT_CYCLES = 1000,
    parameter int WAIT_TIMEOUT      = 4096,
    parameter int MAX_RETRY         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] fail_index,
    output logic       iic_wr_en,
    output logic       iic_rd_en,
    output logic [7:0] iic_addr,
    output logic [7:0] iic_data,
    input  logic       iic_work_done,
    input  logic       iic_ack
);

    localparam int IDX_W   = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam int IDX_CW  = IDX_W + 1;
    localparam int TMR_MAX = max3(255 * DELAY_UNIT_CYCLES, WAIT_TIMEOUT, GAP_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [TMR_W-1:0]  WAIT_LOAD = TMR_W'(WAIT_TIMEOUT - 1);
    localparam logic [IDX_CW-1:0] IDX_END   = IDX_CW'(TABLE_DEPTH);

    cam_state_e        state;
    logic [IDX_CW-1:0] idx;
    logic [IDX_CW-1:0] idx_next;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  delay_load;
    logic              timed_out;
    logic              at_end;
    cam_entry_t        entry;

`ifdef CAM_INIT_RETRY_EN
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    logic [RTY_W-1:0] retry_cnt;
    logic             retry_pend;
`endif

    cam_reg_rom #(.IDX_W(IDX_W)) u_rom (
        .index (idx[IDX_W-1:0]),
        .entry (entry)
    );

    // idx carries one extra bit so that running off the table reads as END.
    assign at_end     = (idx == IDX_END);
    assign idx_next   = at_end ? idx : idx + 1'b1;
    assign delay_load = TMR_W'(32'(entry.val) * 32'(DELAY_UNIT_CYCLES));
    assign iic_rd_en  = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            timer      <= '0;
            timed_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            fail_index <= 8'h00;
            iic_wr_en  <= 1'b0;
            iic_addr   <= 8'h00;
            iic_data   <= 8'h00;
`ifdef CAM_INIT_RETRY_EN
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
`endif
        end else begin
            iic_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state      <= S_FETCH;
                        idx        <= '0;
                        fail_index <= 8'h00;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
`ifdef CAM_INIT_RETRY_EN
                        retry_cnt  <= '0;
                        retry_pend <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (at_end || entry.addr == ADDR_END) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (entry.addr == ADDR_DELAY) begin
                        timer <= delay_load;
                        state <= S_DELAY;
                    end else begin
                        iic_addr <= entry.addr;
                        iic_data <= entry.val;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    iic_wr_en <= 1'b1;
                    timer     <= WAIT_LOAD;
                    timed_out <= 1'b0;
                    state     <= S_WAIT_START;
                end
                // A stale work_done=1 from the last transfer must not count as completion.
                S_WAIT_START: begin
                    if (!iic_work_done) begin
                        timer <= WAIT_LOAD;
                        state <= S_WAIT_DONE;
                    end else if (timer == '0) begin
                        timed_out <= 1'b1;
                        state     <= S_CHECK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (iic_work_done) begin
                        state <= S_CHECK;
                    end else if (timer == '0) begin
                        timed_out <= 1'b1;
                        state     <= S_CHECK;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (iic_ack || timed_out) begin
`ifdef CAM_INIT_RETRY_EN
                        if (retry_cnt < RTY_MAX) begin
                            retry_cnt  <= retry_cnt + 1'b1;
                            retry_pend <= 1'b1;
                            timer      <= GAP_LOAD;
                            state      <= S_GAP;
                        end else
`endif
                        begin
                            state      <= S_FAIL;
                            error      <= 1'b1;
                            busy       <= 1'b0;
                            fail_index <= 8'(idx);
                        end
                    end else begin
`ifdef CAM_INIT_RETRY_EN
                        retry_cnt <= '0;
`endif
                        timer <= GAP_LOAD;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
`ifdef CAM_INIT_RETRY_EN
                        if (retry_pend) begin
                            retry_pend <= 1'b0;
                            state      <= S_ISSUE;
                        end else
`endif
                        begin
                            idx   <= idx_next;
                            state <= S_FETCH;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_DELAY: begin
                    if (timer == '0) begin
                        idx   <= idx_next;
                        state <= S_FETCH;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_reg_init.sv
// Self-checking bench for cam_reg_init with a randomized-latency IIC driver model.
module tb_cam_reg_init;

    localparam int GAP  = 16;
    localparam int DU   = 1000;
    localparam int WTO  = 4096;
    localparam int MAXR = 3;
`ifdef CAM_INIT_RETRY_EN
    localparam int RETRIES = MAXR;
`else
    localparam int RETRIES = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [7:0] fail_index;
    logic       iic_wr_en, iic_rd_en;
    logic [7:0] iic_addr, iic_data;
    logic       iic_work_done;
    logic       iic_ack;

    cam_reg_init #(
        .TABLE_DEPTH(128), .GAP_CYCLES(GAP), .DELAY_UNIT_CYCLES(DU),
        .WAIT_TIMEOUT(WTO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .fail_index(fail_index), .iic_wr_en(iic_wr_en), .iic_rd_en(iic_rd_en),
        .iic_addr(iic_addr), .iic_data(iic_data),
        .iic_work_done(iic_work_done), .iic_ack(iic_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default configuration table as documented for the product.
    logic [7:0] tbl_a [9] = '{8'h12, 8'hFE, 8'h11, 8'h0C, 8'h3E, 8'hFE, 8'h70, 8'h71, 8'hFF};
    logic [7:0] tbl_d [9] = '{8'h80, 8'h02, 8'h01, 8'h04, 8'h19, 8'h00, 8'h3A, 8'h35, 8'h00};

    int tests = 0;
    int failed = 0;

    logic [7:0] nack_addr = 8'h00;
    int         nack_left = 0;
    bit         hang_en = 1'b0;
    logic [7:0] hang_addr = 8'h00;

    int         drv_phase = 0;
    int         drv_cnt = 0;
    logic [7:0] cur_a, cur_d;
    int         hold_err = 0;
    int         rd_err = 0;

    logic [7:0] log_a[$], log_d[$];
    int         log_c[$], cmp_c[$];
    logic [7:0] exp_a[$], exp_d[$];
    bit         exp_err;
    int         exp_fidx;
    int         t_start;

    // Driver model: accepts a write, drops work_done, later raises it with an ack status.
    initial begin
        iic_work_done = 1'b1;
        iic_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (iic_rd_en !== 1'b0) rd_err++;
            if (rst !== 1'b1) begin
                drv_phase = 0;
                iic_work_done = 1'b1;
                iic_ack = 1'b0;
            end else begin
                if (iic_wr_en === 1'b1) begin
                    log_a.push_back(iic_addr);
                    log_d.push_back(iic_data);
                    log_c.push_back(cyc);
                end
                if (drv_phase != 0 && (iic_addr !== cur_a || iic_data !== cur_d)) hold_err++;
                case (drv_phase)
                    0: if (iic_wr_en === 1'b1) begin
                        cur_a = iic_addr;
                        cur_d = iic_data;
                        drv_cnt = $urandom_range(0, 3);
                        drv_phase = 1;
                    end
                    1: if (drv_cnt == 0) begin
                        if (hang_en && cur_a == hang_addr) drv_phase = 3;
                        else begin
                            iic_work_done = 1'b0;
                            iic_ack = 1'b0;
                            drv_cnt = $urandom_range(3, 12);
                            drv_phase = 2;
                        end
                    end else drv_cnt--;
                    2: if (drv_cnt == 0) begin
                        iic_ack = (cur_a == nack_addr && nack_left > 0);
                        if (iic_ack) nack_left--;
                        iic_work_done = 1'b1;
                        cmp_c.push_back(cyc);
                        drv_phase = 0;
                    end else drv_cnt--;
                    default: ;
                endcase
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: expected write sequence and outcome from the table rules.
    task automatic build_expect(input logic [7:0] na, input int nacks, input bit hg, input logic [7:0] ha);
        int left, tries;
        bit stop, f;
        exp_a.delete(); exp_d.delete();
        exp_err = 1'b0; exp_fidx = 0; left = nacks; stop = 1'b0;
        for (int i = 0; i < 9 && !stop; i++) begin
            if (tbl_a[i] == 8'hFF) break;
            if (tbl_a[i] == 8'hFE) continue;
            tries = 0;
            while (1) begin
                exp_a.push_back(tbl_a[i]);
                exp_d.push_back(tbl_d[i]);
                f = hg && tbl_a[i] == ha;
                if (!f && tbl_a[i] == na && left > 0) begin left--; f = 1'b1; end
                if (!f) break;
                tries++;
                if (tries > RETRIES) begin stop = 1'b1; break; end
            end
            if (stop) begin exp_err = 1'b1; exp_fidx = i; end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
        for (int k = 0; k < n; k++)
            if (log_a[k] !== exp_a[k] || log_d[k] !== exp_d[k]) return k;
        if (log_a.size() != exp_a.size()) return n;
        return -1;
    endfunction

    function automatic logic [15:0] log_pair(input int k);
        if (k >= 0 && k < log_a.size()) return {log_a[k], log_d[k]};
        return 16'hxxxx;
    endfunction

    function automatic logic [15:0] exp_pair(input int k);
        if (k >= 0 && k < exp_a.size()) return {exp_a[k], exp_d[k]};
        return 16'hxxxx;
    endfunction

    task automatic clear_logs();
        log_a.delete(); log_d.delete(); log_c.delete(); cmp_c.delete();
        hold_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        hang_en = 1'b0;
        nack_left = 0;
        repeat (3) @(negedge clk);
        clear_logs();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_start();
        @(negedge clk);
        start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, error, iic_wr_en, iic_rd_en} !== 5'b0) begin
            failed++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, error, iic_wr_en, iic_rd_en});
        end
        tests++;
        if (fail_index !== 8'h00) begin
            failed++;
            $display("FAIL reset_fail_index: got %02h expected 00", fail_index);
        end
        tests++;
        if ({iic_addr, iic_data} !== 16'h0000) begin
            failed++;
            $display("FAIL reset_addr_data: got %04h expected 0000", {iic_addr, iic_data});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal();
        bit ok;
        int d, g;
        do_reset();
        build_expect(8'h00, 0, 1'b0, 8'h00);
        run_start();
        tests++;
        if (busy !== 1'b1) begin failed++; $display("FAIL normal_busy_after_start: got %b expected 1", busy); end
        wait_end(20000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL normal_timeout: got no done/error expected done"); end
        tests++;
        if (log_c.size() == 0 || log_c[0] - t_start != 3) begin
            failed++;
            $display("FAIL normal_first_latency: got %0d expected 3", log_c.size() ? log_c[0] - t_start : -1);
        end
        d = first_diff();
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL normal_writes: at %0d got %04h (n=%0d) expected %04h (n=%0d)",
                     d, log_pair(d), log_a.size(), exp_pair(d), exp_a.size());
        end
        for (int k = 1; k < log_c.size() && k <= cmp_c.size(); k++) begin
            g = log_c[k] - cmp_c[k-1];
            tests++;
            if (k == 1) begin
                if (g < 2*DU + GAP || g > 2*DU + GAP + 24) begin
                    failed++;
                    $display("FAIL normal_delay_gap: got %0d expected %0d..%0d", g, 2*DU + GAP, 2*DU + GAP + 24);
                end
            end else if (g < GAP || g > GAP + 10) begin
                failed++;
                $display("FAIL normal_gap_%0d: got %0d expected %0d..%0d", k, g, GAP, GAP + 10);
            end
        end
        tests++;
        if ({done, busy, error} !== 3'b100) begin
            failed++;
            $display("FAIL normal_status: got done/busy/error=%b expected 100", {done, busy, error});
        end
        tests++;
        if (hold_err != 0 || rd_err != 0) begin
            failed++;
            $display("FAIL normal_hold_rd: got hold_err=%0d rd_err=%0d expected 0/0", hold_err, rd_err);
        end
    endtask

    task automatic test_nack_fail();
        bit ok;
        int d, n;
        do_reset();
        nack_addr = 8'h11;
        nack_left = 100;
        build_expect(8'h11, 100, 1'b0, 8'h00);
        run_start();
        wait_end(30000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL nack_timeout: got no done/error expected error"); end
        d = first_diff();
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL nack_writes: at %0d got %04h (n=%0d) expected %04h (n=%0d)",
                     d, log_pair(d), log_a.size(), exp_pair(d), exp_a.size());
        end
        tests++;
        if ({error, done, busy} !== 3'b100 || fail_index !== 8'(exp_fidx)) begin
            failed++;
            $display("FAIL nack_status: got err/done/busy=%b idx=%0d expected 100 idx=%0d",
                     {error, done, busy}, fail_index, exp_fidx);
        end
        n = log_a.size();
        repeat (300) @(negedge clk);
        tests++;
        if (log_a.size() != n) begin
            failed++;
            $display("FAIL nack_no_more_writes: got %0d writes expected %0d", log_a.size(), n);
        end
    endtask

    task automatic test_retry();
        bit ok;
        int d, mg;
        do_reset();
        nack_addr = 8'h11;
        nack_left = 2;
        build_expect(8'h11, 2, 1'b0, 8'h00);
        run_start();
        wait_end(30000, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL retry_timeout: got no done/error expected end"); end
        d = first_diff();
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL retry_writes: at %0d got %04h (n=%0d) expected %04h (n=%0d)",
                     d, log_pair(d), log_a.size(), exp_pair(d), exp_a.size());
        end
        tests++;
        if (error !== exp_err || done !== !exp_err || (exp_err && fail_index !== 8'(exp_fidx))) begin
            failed++;
            $display("FAIL retry_status: got err=%b done=%b idx=%0d expected err=%b idx=%0d",
                     error, done, fail_index, exp_err, exp_fidx);
        end
        mg = 1 << 30;
        for (int k = 1; k < log_c.size() && k <= cmp_c.size(); k++)
            if (log_c[k] - cmp_c[k-1] < mg) mg = log_c[k] - cmp_c[k-1];
        tests++;
        if (mg < GAP) begin failed++; $display("FAIL retry_min_gap: got %0d expected >= %0d", mg, GAP); end
    endtask

    task automatic test_timeout();
        bit ok;
        int d, dt;
        do_reset();
        hang_en = 1'b1;
        hang_addr = 8'h0C;
        build_expect(8'h00, 0, 1'b1, 8'h0C);
        run_start();
        wait_end(30000, ok);
        tests++;
        if (!ok || error !== 1'b1) begin
            failed++;
            $display("FAIL timeout_error: got error=%b expected 1", error);
        end
        tests++;
        if (fail_index !== 8'(exp_fidx)) begin
            failed++;
            $display("FAIL timeout_fail_index: got %0d expected %0d", fail_index, exp_fidx);
        end
        d = first_diff();
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL timeout_writes: at %0d got %04h (n=%0d) expected %04h (n=%0d)",
                     d, log_pair(d), log_a.size(), exp_pair(d), exp_a.size());
        end
        dt = (log_c.size() > 0) ? cyc - log_c[log_c.size()-1] : -1;
        tests++;
        if (dt < WTO || dt > WTO + 10) begin
            failed++;
            $display("FAIL timeout_duration: got %0d expected %0d..%0d", dt, WTO, WTO + 10);
        end
        hang_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int d;
        do_reset();
        run_start();
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (drv_phase == 2) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        tests++;
        if (!seen) begin failed++; $display("FAIL midrst_reach_wait: got no transfer expected one"); end
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, error, iic_wr_en, fail_index, iic_addr, iic_data} !== 28'h0) begin
            failed++;
            $display("FAIL midrst_outputs: got %07h expected 0000000",
                     {busy, done, error, iic_wr_en, fail_index, iic_addr, iic_data});
        end
        @(negedge clk);
        clear_logs();
        rst = 1'b1;
        build_expect(8'h00, 0, 1'b0, 8'h00);
        run_start();
        wait_end(20000, ok);
        d = first_diff();
        tests++;
        if (!ok || d >= 0 || done !== 1'b1) begin
            failed++;
            $display("FAIL midrst_replay: at %0d got %04h (n=%0d done=%b) expected %04h (n=%0d done=1)",
                     d, log_pair(d), log_a.size(), done, exp_pair(d), exp_a.size());
        end
    endtask

    task automatic test_start_held();
        bit ok;
        do_reset();
        build_expect(8'h00, 0, 1'b0, 8'h00);
        @(negedge clk);
        start = 1'b1;
        wait_end(20000, ok);
        tests++;
        if (!ok || done !== 1'b1 || log_a.size() != exp_a.size()) begin
            failed++;
            $display("FAIL held_one_pass: got done=%b writes=%0d expected done=1 writes=%0d",
                     done, log_a.size(), exp_a.size());
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failed++;
            $display("FAIL held_restart_from_done: got busy=%b done=%b expected 1/0", busy, done);
        end
        start = 1'b0;
        wait_end(20000, ok);
        tests++;
        if (!ok || log_a.size() != 2 * exp_a.size()) begin
            failed++;
            $display("FAIL held_second_pass: got writes=%0d expected %0d", log_a.size(), 2 * exp_a.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int d, nk;
        logic [7:0] cand [6];
        logic [7:0] na;
        cand = '{8'h12, 8'h11, 8'h0C, 8'h3E, 8'h70, 8'h71};
        do_reset();
        for (int it = 0; it < 4; it++) begin
            na = cand[$urandom_range(0, 5)];
            nk = $urandom_range(0, 5);
            @(negedge clk);
            clear_logs();
            nack_addr = na;
            nack_left = nk;
            build_expect(na, nk, 1'b0, 8'h00);
            run_start();
            wait_end(30000, ok);
            d = first_diff();
            tests++;
            if (!ok || d >= 0) begin
                failed++;
                $display("FAIL random_%0d_writes (nack %02h x%0d): at %0d got %04h (n=%0d) expected %04h (n=%0d)",
                         it, na, nk, d, log_pair(d), log_a.size(), exp_pair(d), exp_a.size());
            end
            tests++;
            if (error !== exp_err || done !== !exp_err || fail_index !== (exp_err ? 8'(exp_fidx) : 8'h00)) begin
                failed++;
                $display("FAIL random_%0d_status: got err=%b done=%b idx=%0d expected err=%b idx=%0d",
                         it, error, done, fail_index, exp_err, exp_err ? exp_fidx : 0);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_normal();
        test_nack_fail();
        test_retry();
        test_timeout();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
